mdu_seq: RTL and testbench

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_seq_if.sv | 30 +++
 rtl/mdu_seq.sv | 171 +++++++++++++++++
 tb/tb_mdu_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mdu_seq_if.sv
// mdu_seq_if -- request/result bundle for the iterative multiply/divide unit.
//   master: pipeline side (drives start/op/src_a/src_b/flush, reads results)
//   slave : mdu_seq side
//   start, op[1:0], src_a, src_b, flush        request and abort
//   busy, stall, done, hi, lo, div_by_zero     status and HI/LO results
interface mdu_seq_if #(
  parameter int WORD_LEN = 32
);
  logic                start;
  logic [1:0]          op;
  logic [WORD_LEN-1:0] src_a;
  logic [WORD_LEN-1:0] src_b;
  logic                flush;
  logic                busy;
  logic                stall;
  logic                done;
  logic [WORD_LEN-1:0] hi;
  logic [WORD_LEN-1:0] lo;
  logic                div_by_zero;

  modport master (
    output start, op, src_a, src_b, flush,
    input  busy, stall, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output busy, stall, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq -- radix-2 iterative multiply/divide unit with HI/LO result registers.
// op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. One shift-add/subtract step per RUN
// cycle on operand magnitudes; signs are applied when HI/LO are written.
// Divide datapath present only when MDU_DIV_EN is defined; otherwise DIV/DIVU
// complete immediately with HI = LO = 0.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - mdu_seq_if.slave (start/op/src_a/src_b/flush in;
//          busy/stall/done/hi/lo/div_by_zero out)
//
// state  | meaning
// IDLE   | waiting for start; stall follows an accepted request
// RUN    | WORD_LEN iteration cycles, down-counter terminal count at 1
// DONE   | one-cycle done pulse, results valid in hi/lo
module mdu_seq #(
  parameter int WORD_LEN = 32
) (
  input logic       clk,
  input logic       rst,
  mdu_seq_if.slave  bus
);
  localparam int              CNT_W    = $clog2(WORD_LEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WORD_LEN);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t                r_state, w_state_nx;
  logic [CNT_W-1:0]      r_cnt;
  logic [WORD_LEN-1:0]   r_acc, r_shift, r_mcand, r_hi, r_lo;
  logic                  r_neg_res;

  logic                  w_accept, w_last, w_a_neg, w_b_neg;
  logic [WORD_LEN-1:0]   w_mag_a, w_mag_b;
  logic [WORD_LEN:0]     w_sum;
  logic [WORD_LEN-1:0]   w_mul_acc, w_mul_shift, w_acc_nx, w_shift_nx;
  logic [2*WORD_LEN-1:0] w_prod, w_prod_res;

  assign w_accept = (r_state == S_IDLE) && bus.start && !bus.flush;
  assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(1));
  // op[0] set means unsigned, so sign bits only matter for MULT/DIV
  assign w_a_neg  = !bus.op[0] && bus.src_a[WORD_LEN-1];
  assign w_b_neg  = !bus.op[0] && bus.src_b[WORD_LEN-1];
  assign w_mag_a  = w_a_neg ? -bus.src_a : bus.src_a;
  assign w_mag_b  = w_b_neg ? -bus.src_b : bus.src_b;

  // multiply: {acc, shift} shifts right, multiplicand added into acc on LSB
  assign w_sum       = {1'b0, r_acc} + {1'b0, (r_shift[0] ? r_mcand : '0)};
  assign w_mul_acc   = w_sum[WORD_LEN:1];
  assign w_mul_shift = {w_sum[0], r_shift[WORD_LEN-1:1]};
  assign w_prod      = {w_mul_acc, w_mul_shift};
  assign w_prod_res  = r_neg_res ? -w_prod : w_prod;

`ifdef MDU_DIV_EN
  logic                r_div, r_neg_rem, r_dz;
  logic [WORD_LEN-1:0] r_a;
  logic [WORD_LEN:0]   w_trial;
  logic                w_ge;
  logic [WORD_LEN-1:0] w_div_acc, w_div_shift, w_quo, w_rem;

  // restoring divide: {acc, shift} shifts left, quotient bits enter at LSB
  assign w_trial     = {r_acc, r_shift[WORD_LEN-1]};
  assign w_ge        = w_trial >= {1'b0, r_mcand};
  assign w_div_acc   = w_ge ? (w_trial[WORD_LEN-1:0] - r_mcand) : w_trial[WORD_LEN-1:0];
  assign w_div_shift = {r_shift[WORD_LEN-2:0], w_ge};
  assign w_quo       = r_neg_res ? -w_div_shift : w_div_shift;
  assign w_rem       = r_neg_rem ? -w_div_acc : w_div_acc;
  assign w_acc_nx    = r_div ? w_div_acc : w_mul_acc;
  assign w_shift_nx  = r_div ? w_div_shift : w_mul_shift;
  assign bus.div_by_zero = (r_state == S_DONE) && r_dz;
`else
  assign w_acc_nx    = w_mul_acc;
  assign w_shift_nx  = w_mul_shift;
  assign bus.div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef MDU_DIV_EN
          w_state_nx = S_RUN;
`else
          w_state_nx = bus.op[1] ? S_DONE : S_RUN;
`endif
        end
      end
      S_RUN: begin
        if (bus.flush)             w_state_nx = S_IDLE;
        else if (r_cnt == CNT_W'(1)) w_state_nx = S_DONE;
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_shift   <= '0;
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_neg_res <= 1'b0;
`ifdef MDU_DIV_EN
      r_div     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dz      <= 1'b0;
      r_a       <= '0;
`endif
    end else if (w_accept) begin
      r_cnt     <= CNT_LOAD;
      r_acc     <= '0;
      r_neg_res <= w_a_neg ^ w_b_neg;
      r_shift   <= w_mag_b;
      r_mcand   <= w_mag_a;
`ifdef MDU_DIV_EN
      r_div     <= bus.op[1];
      r_neg_rem <= w_a_neg;
      r_a       <= bus.src_a;
      r_dz      <= bus.op[1] && (bus.src_b == '0);
      if (bus.op[1]) begin
        r_shift <= w_mag_a;
        r_mcand <= w_mag_b;
      end
`else
      if (bus.op[1]) begin
        r_hi <= '0;
        r_lo <= '0;
      end
`endif
    end else if (r_state == S_RUN) begin
      if (bus.flush) begin
        r_cnt <= '0;
      end else begin
        r_cnt   <= r_cnt - CNT_W'(1);
        r_acc   <= w_acc_nx;
        r_shift <= w_shift_nx;
        if (w_last) begin
`ifdef MDU_DIV_EN
          if (!r_div) begin
            {r_hi, r_lo} <= w_prod_res;
          end else if (r_dz) begin
            r_hi <= r_a;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
`else
          {r_hi, r_lo} <= w_prod_res;
`endif
        end
      end
    end
  end

  assign bus.busy  = (r_state != S_IDLE);
  // gated by rst so a pending start cannot raise stall while held in reset
  assign bus.stall = rst && (w_accept || (r_state == S_RUN));
  assign bus.done  = (r_state == S_DONE);
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;
endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mdu_seq_if #(.WORD_LEN(32)) bus ();
  mdu_seq #(.WORD_LEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int dcyc, scnt;
  bit seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble operands afterwards, return done cycle and stall count.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit poke, output int d, output int s);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b;
    #1;
    s = bus.stall ? 1 : 0;
    d = -1;
    for (int k = 1; k <= 40 && d < 0; k++) begin
      @(negedge clk);
      bus.start = poke && (k == 5);
      bus.op = o ^ 2'b01; bus.src_a = ~a; bus.src_b = b ^ 32'h5a5a_5a5a;
      #1;
      if (bus.stall) s++;
      if (bus.done) d = k;
    end
    bus.start = 1'b0;
  endtask

  task automatic no_done(input int cycles, output bit sd);
    sd = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk); #1;
      if (bus.done) sd = 1'b1;
    end
  endtask

  initial begin
    bus.start = 1'b1; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0; bus.flush = 1'b0;
    #2;
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dz", bus.div_by_zero, 0);
    @(negedge clk);
    bus.start = 1'b0; rst = 1'b1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, dcyc, scnt);
    chk("multu_ff_done_cyc", dcyc, 33);
    chk("multu_ff_stall_cnt", scnt, 33);
    chk("multu_ff_hi", bus.hi, 32'hFFFF_FFFE);
    chk("multu_ff_lo", bus.lo, 32'h0000_0001);
    chk("multu_ff_dz", bus.div_by_zero, 0);
    @(negedge clk); #1;
    chk("done_pulse_width", bus.done, 0);
    chk("busy_after_done", bus.busy, 0);

    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, dcyc, scnt);
    chk("mult_m3x7_done_cyc", dcyc, 33);
    chk("mult_m3x7_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_m3x7_lo", bus.lo, 32'hFFFF_FFEB);

    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, dcyc, scnt);
    chk("mult_min_sq_hi", bus.hi, 32'h4000_0000);
    chk("mult_min_sq_lo", bus.lo, 32'h0000_0000);

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, dcyc, scnt);
    chk("mult_m1sq_hi", bus.hi, 32'h0000_0000);
    chk("mult_m1sq_lo", bus.lo, 32'h0000_0001);

    run_op(2'b00, 32'h0000_0005, 32'hFFFF_FFFD, 1'b0, dcyc, scnt);
    chk("mult_5xm3_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_5xm3_lo", bus.lo, 32'hFFFF_FFF1);

    run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 1'b0, dcyc, scnt);
    chk("multu_2p32_hi", bus.hi, 32'h0000_0001);
    chk("multu_2p32_lo", bus.lo, 32'h0000_0000);

`ifdef MDU_DIV_EN
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, dcyc, scnt);
    chk("div_m7by2_done_cyc", dcyc, 33);
    chk("div_m7by2_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_m7by2_hi", bus.hi, 32'hFFFF_FFFF);
    chk("div_m7by2_dz", bus.div_by_zero, 0);

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, dcyc, scnt);
    chk("div_ovf_lo", bus.lo, 32'h8000_0000);
    chk("div_ovf_hi", bus.hi, 32'h0000_0000);

    run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, dcyc, scnt);
    chk("div_7bym2_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_7bym2_hi", bus.hi, 32'h0000_0001);

    run_op(2'b11, 32'd100, 32'd7, 1'b0, dcyc, scnt);
    chk("divu_100by7_lo", bus.lo, 32'd14);
    chk("divu_100by7_hi", bus.hi, 32'd2);

    run_op(2'b11, 32'h0000_0005, 32'h0000_0000, 1'b0, dcyc, scnt);
    chk("divu_5by0_lo", bus.lo, 32'hFFFF_FFFF);
    chk("divu_5by0_hi", bus.hi, 32'h0000_0005);
    chk("divu_5by0_dz", bus.div_by_zero, 1);

    run_op(2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 1'b0, dcyc, scnt);
    chk("div_m5by0_lo", bus.lo, 32'hFFFF_FFFF);
    chk("div_m5by0_hi", bus.hi, 32'hFFFF_FFFB);
    chk("div_m5by0_dz", bus.div_by_zero, 1);
    @(negedge clk); #1;
    chk("dz_clears", bus.div_by_zero, 0);
`else
    run_op(2'b11, 32'h0000_0005, 32'h0000_0000, 1'b0, dcyc, scnt);
    chk("nodiv_divu_done_cyc", dcyc, 1);
    chk("nodiv_divu_stall_cnt", scnt, 1);
    chk("nodiv_divu_hi", bus.hi, 0);
    chk("nodiv_divu_lo", bus.lo, 0);
    chk("nodiv_divu_dz", bus.div_by_zero, 0);

    run_op(2'b00, 32'd6, 32'd7, 1'b0, dcyc, scnt);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, dcyc, scnt);
    chk("nodiv_div_done_cyc", dcyc, 1);
    chk("nodiv_div_lo", bus.lo, 0);
`endif

    // flush in RUN after preloading hi/lo = 0/12; start pulse in RUN ignored
    run_op(2'b01, 32'd3, 32'd4, 1'b0, dcyc, scnt);
    chk("multu_3x4_hi", bus.hi, 0);
    chk("multu_3x4_lo", bus.lo, 12);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'd5; bus.src_b = 32'd6;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.start = (k == 3);
      bus.flush = (k == 10);
    end
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    chk("flush_busy", bus.busy, 0);
    chk("flush_stall", bus.stall, 0);
    no_done(40, seen);
    chk("flush_no_done", seen, 0);
    chk("flush_hi", bus.hi, 0);
    chk("flush_lo", bus.lo, 12);

    // flush beats start in IDLE
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b01; bus.src_a = 32'd2; bus.src_b = 32'd3;
    #1;
    chk("flush_prio_stall", bus.stall, 0);
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    #1;
    chk("flush_prio_busy", bus.busy, 0);

    // asynchronous reset mid-RUN
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'd7; bus.src_b = 32'd9;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #2;
    rst = 1'b0;
    bus.start = 1'b1;
    #1;
    chk("arst_hi", bus.hi, 0);
    chk("arst_lo", bus.lo, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_stall", bus.stall, 0);
    chk("arst_done", bus.done, 0);
    @(negedge clk);
    bus.start = 1'b0; rst = 1'b1;
    no_done(40, seen);
    chk("arst_no_done", seen, 0);
    chk("arst_busy_after", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
